pongfpga_ram_reader: RTL and testbench
======================================

Name: pongfpga_ram_reader

Overview:
- Avalon-MM read master; the initiator-side counterpart of the 4096x32 single-port on-chip RAM slave (12-bit word address, 32-bit data, byteenable, fixed read latency).
- On a start pulse, fetches a block of consecutive words from the RAM and presents them in order on a valid/ready stream.
- Consumers are the Pong video/sprite path.
- Flow control is credit-based, so a stalled consumer never drops read data.

Parameters:
- ADDR_W, 12, word address width; matches RAM depth 4096.
- DATA_W, 32, data width.
- READ_LATENCY, 1, cycles from accepted read to valid avm_readdata; fixed, no readdatavalid.
- FIFO_DEPTH, 8, output buffer depth in words (power of 2, ≥ READ_LATENCY+1).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_addr  in  ADDR_W  first word address, captured on start.
- word_count  in  ADDR_W+1  words to read, 0..4096, captured on start.
- abort  in  1  cancel the current transfer.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse on completion or abort completion.
- avm_address  out  ADDR_W  word address.
- avm_chipselect  out  1  equals avm_read.
- avm_read  out  1  read request.
- avm_write  out  1  constant 0.
- avm_byteenable  out  4  constant 4'hF.
- avm_waitrequest  in  1  slave stall; tie 0 for on-chip RAM.
- avm_readdata  in  DATA_W  read data.
- out_data  out  DATA_W  stream data (FIFO head, show-ahead).
- out_valid  out  1  stream valid.
- out_ready  in  1  consumer accept.

Behaviour:
- Reset values:
  - busy, done, avm_read, avm_chipselect, out_valid = 0.
  - avm_address = 0.
  - FIFO empty; all counters 0; state IDLE.
- FSM states: IDLE, ISSUE, DRAIN.
  - IDLE -> ISSUE on start with word_count≠0.
  - start with word_count=0: no bus activity; done pulses the next cycle and busy stays 0.
  - start while not in IDLE is ignored.
- ISSUE:
  - avm_read=1 when remaining_issue>0 and credits available, where credits = FIFO_DEPTH − fifo_count − in_flight.
  - A read is accepted when avm_read & ~avm_waitrequest. On accept: avm_address increments and wraps 4095->0; remaining_issue decrements; in_flight increments.
  - avm_address and avm_read are held stable while waitrequest=1.
  - First avm_read rises in the cycle after start.
- Return path:
  - A READ_LATENCY-deep shift register of accept flags marks when avm_readdata is captured into the FIFO; in_flight decrements at capture.
  - Simultaneous accept and capture leaves in_flight unchanged.
  - Credits guarantee the FIFO never overflows.
- ISSUE -> DRAIN when the last read is accepted.
- DRAIN -> IDLE when in_flight=0 and the last word has been popped (out_valid & out_ready). done pulses in that same cycle; busy falls the following cycle.
- out_valid rises one cycle after the first FIFO write. Simultaneous push and pop keeps fifo_count constant.
- abort, in ISSUE or DRAIN:
  - avm_read drops the next cycle.
  - In-flight returns are discarded, not pushed.
  - FIFO flushed, so out_valid=0 the next cycle.
  - After in_flight reaches 0: done pulse, then IDLE.
  - abort in IDLE has no effect.
- reset_n low mid-transfer: everything returns to reset values immediately and in-flight data is lost.
- word_count=4096 from any base_addr reads every word exactly once, with the wrap.

Decomposition:
- Shared package pongfpga_pkg: ADDR_W/DATA_W defaults, RAM_WORDS=4096, state enum type rd_state_t, BYTEEN_ALL=4'hF.
- Sub-module pongfpga_word_fifo: synchronous show-ahead FIFO, parameterised width/depth, with a flush input and a count output.
- Pointer, credit and FSM logic stay in the top module.

Test Plan:
- Basic read: RAM preloaded with word i = 32'hA000_0000+i; start, base=0x010, count=5, out_ready=1. Expect avm_address 0x010..0x014 on consecutive cycles, out_data A0000010..A0000014 in order, one done pulse, busy low afterwards.
- Wrap-around: base=0xFFE, count=4. Expect addresses FFE, FFF, 000, 001 and data in that order.
- Backpressure: out_ready=0 for 20 cycles, count=16, FIFO_DEPTH=8. Expect exactly 8 reads issued, then avm_read=0. After release, all 16 words arrive with none lost or duplicated.
- Waitrequest: random 0–3 cycle stalls. avm_address must be stable while stalled; 10 words returned correctly.
- Abort: abort on the 3rd read of count=10. Expect avm_read low the next cycle, out_valid low, done within READ_LATENCY+2 cycles, a following start works normally.
- Edge cases:
  - count=0 → done only, no avm_read.
  - start asserted while busy → ignored.
  - reset_n pulsed mid-transfer → all outputs at reset values.

Source files
------------

// File: rtl/pongfpga_pkg.sv
// Shared constants and types for the Pong RAM read master.
package pongfpga_pkg;

    localparam int         ADDR_W_DEF = 12;
    localparam int         DATA_W_DEF = 32;
    localparam int         RAM_WORDS  = 4096;
    localparam logic [3:0] BYTEEN_ALL = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_t;

endpackage

// File: rtl/pongfpga_word_fifo.sv
// Synchronous show-ahead FIFO with flush and occupancy count.
// Head word is visible on head_dat whenever count is non-zero; flush empties it in one cycle.
module pongfpga_word_fifo #(
    parameter int  WIDTH = 32,
    parameter int  DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_push  = push && (count_q != CNT_W'(DEPTH));
        do_pop   = pop && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the count gates every read of it.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= push_dat;
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/pongfpga_ram_reader.sv
// Avalon-MM block read master: fetches word_count words from base_addr into a stream.
// Reads are only issued against free FIFO credits, so a stalled consumer never loses data.
module pongfpga_ram_reader
    import pongfpga_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_read,
    output logic              avm_write,
    output logic [3:0]        avm_byteenable,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    rd_state_t               state_q, state_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [ADDR_W:0]         remaining_q, remaining_d;
    logic [CNT_W-1:0]        in_flight_q, in_flight_d;
    logic [READ_LATENCY-1:0] lat_sr_q, lat_sr_d;
    logic                    aborting_q, aborting_d;
    logic                    done_zero_q, done_zero_d;

    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   used_slots;
    logic             credit_ok, rd_req, accept, capture;
    logic             abort_now, fifo_push, fifo_pop, fifo_flush;
    logic             drain_done, abort_done;

    // Words already buffered plus words still on their way back both consume a slot.
    assign used_slots = {1'b0, fifo_count} + {1'b0, in_flight_q};
    assign credit_ok  = used_slots < (CNT_W + 1)'(FIFO_DEPTH);

    assign rd_req    = (state_q == ST_ISSUE) && (remaining_q != '0) && credit_ok;
    assign accept    = rd_req && !avm_waitrequest;
    assign capture   = lat_sr_q[READ_LATENCY-1];
    assign abort_now = abort && (state_q != ST_IDLE);

    assign fifo_flush = abort_now;
    assign fifo_push  = capture && !aborting_q && !abort_now;
    assign fifo_pop   = out_valid && out_ready;

    assign drain_done = (state_q == ST_DRAIN) && !aborting_q && !abort
                        && (in_flight_q == '0) && (fifo_count == CNT_W'(1)) && fifo_pop;
    assign abort_done = (state_q == ST_DRAIN) && aborting_q && (in_flight_q == '0);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        aborting_d  = aborting_q;
        done_zero_d = 1'b0;
        in_flight_d = in_flight_q + CNT_W'(accept) - CNT_W'(capture);

        lat_sr_d[0] = accept;
        for (int i = 1; i < READ_LATENCY; i++) begin
            lat_sr_d[i] = lat_sr_q[i-1];
        end

        if (accept) begin
            addr_d      = addr_q + ADDR_W'(1);
            remaining_d = remaining_q - (ADDR_W + 1)'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d      = base_addr;
                    remaining_d = word_count;
                    aborting_d  = 1'b0;
                    if (word_count == '0) done_zero_d = 1'b1;
                    else                  state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (abort) begin
                    state_d    = ST_DRAIN;
                    aborting_d = 1'b1;
                end else if (accept && (remaining_q == (ADDR_W + 1)'(1))) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (abort) aborting_d = 1'b1;
                if (drain_done || abort_done) begin
                    state_d    = ST_IDLE;
                    aborting_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            in_flight_q <= '0;
            lat_sr_q    <= '0;
            aborting_q  <= 1'b0;
            done_zero_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            in_flight_q <= in_flight_d;
            lat_sr_q    <= lat_sr_d;
            aborting_q  <= aborting_d;
            done_zero_q <= done_zero_d;
        end
    end

    pongfpga_word_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush    (fifo_flush),
        .push     (fifo_push),
        .push_dat (avm_readdata),
        .pop      (fifo_pop),
        .head_dat (out_data),
        .count    (fifo_count)
    );

    assign out_valid      = (fifo_count != '0);
    assign busy           = (state_q != ST_IDLE);
    assign done           = done_zero_q || drain_done || abort_done;
    assign avm_address    = addr_q;
    assign avm_read       = rd_req;
    assign avm_chipselect = rd_req;
    assign avm_write      = 1'b0;
    assign avm_byteenable = BYTEEN_ALL;

endmodule

// File: tb/tb_pongfpga_ram_reader.sv
// Directed bench for pongfpga_ram_reader against a 4096x32 RAM model holding A000_0000+addr.
module tb_pongfpga_ram_reader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [11:0] base_addr = '0;
    logic [12:0] word_count = '0;
    logic        abort = 1'b0;
    logic        busy, done;
    logic [11:0] avm_address;
    logic        avm_chipselect, avm_read, avm_write;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata = '0;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    logic [11:0] acc_addr[$];
    int          acc_cyc[$];
    logic [31:0] rx[$];
    logic [31:0] ram [4096];

    pongfpga_ram_reader dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .base_addr       (base_addr),
        .word_count      (word_count),
        .abort           (abort),
        .busy            (busy),
        .done            (done),
        .avm_address     (avm_address),
        .avm_chipselect  (avm_chipselect),
        .avm_read        (avm_read),
        .avm_write       (avm_write),
        .avm_byteenable  (avm_byteenable),
        .avm_waitrequest (avm_waitrequest),
        .avm_readdata    (avm_readdata),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // One-cycle-latency RAM slave.
    always @(posedge clk) begin
        if (avm_read && !avm_waitrequest) avm_readdata <= ram[avm_address];
    end

    always @(negedge clk) begin
        if (reset_n) begin
            if (avm_read && !avm_waitrequest) begin
                acc_addr.push_back(avm_address);
                acc_cyc.push_back(cyc);
            end
            if (out_valid && out_ready) rx.push_back(out_data);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        acc_addr.delete();
        acc_cyc.delete();
        rx.delete();
        done_cnt = 0;
    endtask

    task automatic do_start(input logic [11:0] b, input logic [12:0] n);
        start      = 1'b1;
        base_addr  = b;
        word_count = n;
        start_cyc  = cyc;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done_cnt > 0) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) step();
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (avm_read !== 1'b0 || avm_chipselect !== 1'b0) begin n_errors++; $display("FAIL reset_read: got %b/%b want 0/0", avm_read, avm_chipselect); end
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_checks++; if (avm_address !== 12'h000) begin n_errors++; $display("FAIL reset_addr: got %h want 000", avm_address); end
        n_checks++; if (avm_write !== 1'b0 || avm_byteenable !== 4'hF) begin n_errors++; $display("FAIL const_outputs: got %b/%h want 0/f", avm_write, avm_byteenable); end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        bit ok;
        clear_mon();
        out_ready = 1'b1;
        do_start(12'h010, 13'd5);
        n_checks++; if (avm_read !== 1'b1 || avm_address !== 12'h010) begin n_errors++; $display("FAIL basic_first_read: got %b@%h want 1@010", avm_read, avm_address); end
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL basic_busy: got %b want 1", busy); end
        wait_done(50, ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL basic_timeout: got no done want done"); end
        step();
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL basic_busy_after: got %b want 0", busy); end
        n_checks++; if (acc_addr.size() != 5) begin n_errors++; $display("FAIL basic_nreads: got %0d want 5", acc_addr.size()); end
        for (int i = 0; i < 5 && i < acc_addr.size(); i++) begin
            n_checks++;
            if (acc_addr[i] !== 12'(12'h010 + i) || acc_cyc[i] != start_cyc + 1 + i) begin
                n_errors++; $display("FAIL basic_addr[%0d]: got %h@%0d want %h@%0d", i, acc_addr[i], acc_cyc[i], 12'(12'h010 + i), start_cyc + 1 + i);
            end
        end
        n_checks++; if (rx.size() != 5) begin n_errors++; $display("FAIL basic_nwords: got %0d want 5", rx.size()); end
        for (int i = 0; i < 5 && i < rx.size(); i++) begin
            n_checks++;
            if (rx[i] !== 32'hA000_0010 + 32'(i)) begin n_errors++; $display("FAIL basic_data[%0d]: got %h want %h", i, rx[i], 32'hA000_0010 + 32'(i)); end
        end
        n_checks++; if (done_cnt != 1 || done_cyc != start_cyc + 7) begin n_errors++; $display("FAIL basic_done: got %0d pulses @%0d want 1 @%0d", done_cnt, done_cyc, start_cyc + 7); end
    endtask

    task automatic test_wrap();
        bit ok;
        logic [11:0] exp_a [4] = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
        clear_mon();
        out_ready = 1'b1;
        do_start(12'hFFE, 13'd4);
        wait_done(50, ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL wrap_timeout: got no done want done"); end
        step();
        n_checks++; if (acc_addr.size() != 4 || rx.size() != 4) begin n_errors++; $display("FAIL wrap_count: got %0d/%0d want 4/4", acc_addr.size(), rx.size()); end
        for (int i = 0; i < 4 && i < acc_addr.size() && i < rx.size(); i++) begin
            n_checks++;
            if (acc_addr[i] !== exp_a[i] || rx[i] !== (32'hA000_0000 | 32'(exp_a[i]))) begin
                n_errors++; $display("FAIL wrap[%0d]: got %h/%h want %h/%h", i, acc_addr[i], rx[i], exp_a[i], 32'hA000_0000 | 32'(exp_a[i]));
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        clear_mon();
        out_ready = 1'b0;
        do_start(12'h100, 13'd16);
        repeat (19) step();
        n_checks++; if (acc_addr.size() != 8) begin n_errors++; $display("FAIL bp_reads_issued: got %0d want 8", acc_addr.size()); end
        n_checks++; if (avm_read !== 1'b0) begin n_errors++; $display("FAIL bp_read_held: got %b want 0", avm_read); end
        n_checks++; if (out_valid !== 1'b1 || out_data !== 32'hA000_0100) begin n_errors++; $display("FAIL bp_head: got %b/%h want 1/a0000100", out_valid, out_data); end
        out_ready = 1'b1;
        wait_done(100, ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL bp_timeout: got no done want done"); end
        step();
        n_checks++; if (rx.size() != 16 || acc_addr.size() != 16) begin n_errors++; $display("FAIL bp_count: got %0d/%0d want 16/16", rx.size(), acc_addr.size()); end
        for (int i = 0; i < 16 && i < rx.size(); i++) begin
            n_checks++;
            if (rx[i] !== 32'hA000_0100 + 32'(i)) begin n_errors++; $display("FAIL bp_data[%0d]: got %h want %h", i, rx[i], 32'hA000_0100 + 32'(i)); end
        end
    endtask

    task automatic test_waitrequest();
        int          stall_left = 2;
        int          stalls = 0;
        bit          prev_stall = 1'b0;
        logic [11:0] prev_addr = '0;
        clear_mon();
        out_ready = 1'b1;
        do_start(12'h200, 13'd10);
        for (int i = 0; i < 300; i++) begin
            if (prev_stall) begin
                n_checks++;
                if (avm_read !== 1'b1 || avm_address !== prev_addr) begin
                    n_errors++; $display("FAIL wr_stable: got %b@%h want 1@%h", avm_read, avm_address, prev_addr);
                end
            end
            if (done_cnt > 0) break;
            if (avm_read && stall_left > 0) begin
                avm_waitrequest = 1'b1;
                stall_left--;
                stalls++;
            end else begin
                avm_waitrequest = 1'b0;
                if (avm_read) stall_left = $urandom_range(0, 3);
            end
            prev_stall = avm_read && avm_waitrequest;
            prev_addr  = avm_address;
            step();
        end
        avm_waitrequest = 1'b0;
        step();
        n_checks++; if (done_cnt != 1) begin n_errors++; $display("FAIL wr_done: got %0d want 1", done_cnt); end
        n_checks++; if (stalls == 0) begin n_errors++; $display("FAIL wr_stalls: got 0 want >0"); end
        n_checks++; if (rx.size() != 10 || acc_addr.size() != 10) begin n_errors++; $display("FAIL wr_count: got %0d/%0d want 10/10", rx.size(), acc_addr.size()); end
        for (int i = 0; i < 10 && i < rx.size(); i++) begin
            n_checks++;
            if (rx[i] !== 32'hA000_0200 + 32'(i)) begin n_errors++; $display("FAIL wr_data[%0d]: got %h want %h", i, rx[i], 32'hA000_0200 + 32'(i)); end
        end
    endtask

    task automatic test_abort();
        bit ok;
        int abort_cyc;
        clear_mon();
        out_ready = 1'b1;
        do_start(12'h300, 13'd10);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (acc_addr.size() == 2 && avm_read) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        n_checks++; if (!ok || avm_address !== 12'h302) begin n_errors++; $display("FAIL abort_third_read: got %b@%h want 1@302", ok, avm_address); end
        abort     = 1'b1;
        abort_cyc = cyc;
        step();
        abort = 1'b0;
        n_checks++; if (avm_read !== 1'b0) begin n_errors++; $display("FAIL abort_read_drop: got %b want 0", avm_read); end
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL abort_flush: got %b want 0", out_valid); end
        for (int i = 0; i < 4; i++) begin
            if (done_cnt > 0) break;
            step();
        end
        n_checks++; if (done_cnt != 1 || done_cyc > abort_cyc + 3) begin n_errors++; $display("FAIL abort_done: got %0d pulses @%0d want 1 by %0d", done_cnt, done_cyc, abort_cyc + 3); end
        step();
        n_checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_errors++; $display("FAIL abort_idle: got busy %b valid %b want 0/0", busy, out_valid); end
        repeat (3) step();
        n_checks++; if (acc_addr.size() != 3 || rx.size() > 3) begin n_errors++; $display("FAIL abort_counts: got %0d reads %0d words want 3 reads <=3 words", acc_addr.size(), rx.size()); end
        for (int i = 0; i < rx.size(); i++) begin
            n_checks++;
            if (rx[i] !== 32'hA000_0300 + 32'(i)) begin n_errors++; $display("FAIL abort_prefix[%0d]: got %h want %h", i, rx[i], 32'hA000_0300 + 32'(i)); end
        end
        clear_mon();
        do_start(12'h400, 13'd3);
        wait_done(50, ok);
        step();
        n_checks++; if (!ok || rx.size() != 3) begin n_errors++; $display("FAIL abort_restart: got %0d words want 3", rx.size()); end
        for (int i = 0; i < 3 && i < rx.size(); i++) begin
            n_checks++;
            if (rx[i] !== 32'hA000_0400 + 32'(i)) begin n_errors++; $display("FAIL abort_restart_data[%0d]: got %h want %h", i, rx[i], 32'hA000_0400 + 32'(i)); end
        end
    endtask

    task automatic test_edge_cases();
        bit ok;
        clear_mon();
        out_ready = 1'b1;
        do_start(12'h050, 13'd0);
        n_checks++; if (done !== 1'b1 || busy !== 1'b0 || avm_read !== 1'b0) begin n_errors++; $display("FAIL zero_count: got done %b busy %b read %b want 1/0/0", done, busy, avm_read); end
        step();
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL zero_done_pulse: got %b want 0", done); end
        repeat (3) step();
        n_checks++; if (acc_addr.size() != 0 || done_cnt != 1 || busy !== 1'b0) begin n_errors++; $display("FAIL zero_quiet: got %0d reads %0d dones busy %b want 0/1/0", acc_addr.size(), done_cnt, busy); end

        clear_mon();
        do_start(12'h500, 13'd6);
        step();
        do_start(12'h700, 13'd2);
        wait_done(50, ok);
        repeat (4) step();
        n_checks++; if (!ok || done_cnt != 1 || acc_addr.size() != 6 || rx.size() != 6) begin n_errors++; $display("FAIL start_busy: got %0d dones %0d reads %0d words want 1/6/6", done_cnt, acc_addr.size(), rx.size()); end
        for (int i = 0; i < 6 && i < rx.size() && i < acc_addr.size(); i++) begin
            n_checks++;
            if (acc_addr[i] !== 12'(12'h500 + i) || rx[i] !== 32'hA000_0500 + 32'(i)) begin n_errors++; $display("FAIL start_busy_data[%0d]: got %h/%h want %h/%h", i, acc_addr[i], rx[i], 12'(12'h500 + i), 32'hA000_0500 + 32'(i)); end
        end

        clear_mon();
        out_ready = 1'b0;
        do_start(12'h600, 13'd10);
        repeat (3) step();
        reset_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0 || avm_read !== 1'b0 || avm_chipselect !== 1'b0 || out_valid !== 1'b0 || avm_address !== 12'h000) begin
            n_errors++; $display("FAIL mid_reset: got busy %b done %b read %b cs %b valid %b addr %h want 0/0/0/0/0/000", busy, done, avm_read, avm_chipselect, out_valid, avm_address);
        end
        step();
        reset_n   = 1'b1;
        out_ready = 1'b1;
        step();
        clear_mon();
        do_start(12'h020, 13'd2);
        wait_done(50, ok);
        step();
        n_checks++; if (!ok || rx.size() != 2 || rx[0] !== 32'hA000_0020 || rx[1] !== 32'hA000_0021) begin n_errors++; $display("FAIL post_reset: got %0d words want 2 (a0000020,a0000021)", rx.size()); end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 32'hA000_0000 + 32'(i);
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_waitrequest();
        test_abort();
        test_edge_cases();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
